pipe_trace_buffer: RTL
======================

# pipe_trace_buffer

Parametrised, synthesizable trace capture unit for the pipelined RISC-V core. It records per-cycle debug probes (IF PC, ID instruction, EX ALU result, WB write data) into a circular buffer. Capture freezes a programmable number of samples after a PC-match trigger, and the frozen window is then streamed out over a valid/ready port. It moves the pipeline visibility we currently get only from simulation printouts into hardware, and is instantiated beside the processor top.

## Interface
- DATA_W, default 8: width of each probe field and of the trigger PC.
- DEPTH, default 16: buffer entries; power of two, at least 4.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- output_en  in  1  capture qualifier; samples are ignored while it is low.
- probe_valid  in  1  probe fields hold a valid sample this cycle.
- probe_pc, probe_instr, probe_alu, probe_wb  in  DATA_W each  probe fields.
- arm  in  1  pulse: start a capture; honoured in IDLE only.
- abort  in  1  pulse: return to IDLE from any state.
- dump  in  1  pulse: start readout; honoured in DONE only.
- trig_pc  in  DATA_W  PC value that triggers capture.
- post_trig  in  clog2(DEPTH)+1  number of samples to keep after the trigger sample; sampled at trigger.
- rd_valid  out  1  rd_data holds a valid entry.
- rd_ready  in  1  consumer accepts the entry.
- rd_data  out  4*DATA_W  entry packed as {wb, alu, instr, pc}, with pc in the LSBs.
- rd_last  out  1  current entry is the final entry of the dump.
- state  out  3  IDLE=0, ARMED=1, POST=2, DONE=3, DUMP=4.
- triggered  out  1  trigger has fired in the current capture.
- fill_count  out  clog2(DEPTH)+1  number of valid entries, 0..DEPTH.

## Operation
- A sample is taken when state is ARMED or POST, output_en=1 and probe_valid=1. The sample is written to mem[wp]; wp increments modulo DEPTH; fill_count saturates at DEPTH.
- IDLE: arm sets wp=0, fill_count=0, triggered=0, then moves to ARMED.
- ARMED: the trigger is a sample with probe_pc==trig_pc. The triggering sample is written and triggered is set.
  - The trigger latches rem = min(post_trig, DEPTH-1).
  - If rem==0, go to DONE; otherwise go to POST.
- POST: each sample decrements rem. The sample that brings rem to 0 moves the block to DONE.
- DONE: the buffer is frozen and samples are ignored.
  - dump sets rp=(wp-fill_count) mod DEPTH and cnt=fill_count, then moves to DUMP.
- DUMP:
  - rd_valid=1 and rd_data=mem[rp].
  - rd_last=1 when cnt==1.
  - On rd_valid&&rd_ready, rp increments modulo DEPTH and cnt decrements.
  - The handshake on the last entry moves the block to IDLE and clears fill_count and triggered.
- Entries are output oldest first. After wrap-around the window holds exactly the last DEPTH samples.
- abort in any state goes to IDLE. It clears rd_valid, fill_count and triggered. Memory contents are don't-care.
- Priority: rst > abort > arm/dump/trigger. Commands not legal in the current state are ignored.
- rd_data and rd_last are 0 whenever rd_valid=0.

## Timing
- rst held for at least one edge gives state=0, rd_valid=0, rd_data=0, rd_last=0, triggered=0 and fill_count=0 on the next cycle.
- arm is sampled at edge N, and state=ARMED after N. The first capturable sample is the one presented in the cycle after edge N.
- The trigger sample at edge N gives state=POST or DONE and triggered=1 after N.
- dump at edge N gives rd_valid=1 in the cycle after N. With rd_ready held high, one entry transfers per cycle and rd_valid drops in the cycle after the last handshake.
- While rd_valid=1 and rd_ready=0, rd_data and rd_last hold stable.
- fill_count reflects writes the cycle after each write edge.
- Memory is a register array read asynchronously at rp. There is no extra read latency.

## Test plan
- Reset: assert rst for 2 cycles while driving arm=1 → state=0, rd_valid=0, fill_count=0, triggered=0.
- Basic capture, DATA_W=8, DEPTH=16: arm with trig_pc=0x10 and post_trig=2, then feed pc=0x00,0x04,…,0x18 (7 samples) → DONE with fill_count=7; dump yields pc 0x00…0x18 in order, rd_last only on 0x18, then IDLE.
- Wrap: arm with trig_pc=35 and post_trig=4, then feed pc=0..39 → fill_count=16; dump yields pc 24..39 in order.
- Clamp and gating:
  - post_trig=20 with trigger at pc=3 → exactly 15 post samples kept, and the trigger entry is oldest-but-none-lost when total ≤16.
  - Samples with output_en=0 or probe_valid=0 are absent from the dump.
- Backpressure: toggle rd_ready pseudo-randomly during a 16-entry dump → each entry is delivered once, in order, and rd_data stays stable while stalled.
- Abort:
  - abort on the 3rd entry of a dump → rd_valid=0 and state=0 the next cycle.
  - arm and abort in the same cycle from IDLE → state stays 0.
  - dump while ARMED → ignored.

Source files
------------

// File: rtl/pipe_trace_buffer.sv
`default_nettype none
// ============================================================================
// pipe_trace_buffer : circular capture of pipeline probes with PC trigger,
//                     post-trigger freeze and valid/ready readout.
// Revision 1.0
// ============================================================================
module pipe_trace_buffer #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        output_en,
   input  logic                        probe_valid,
   input  logic [DATA_W-1:0]           probe_pc,
   input  logic [DATA_W-1:0]           probe_instr,
   input  logic [DATA_W-1:0]           probe_alu,
   input  logic [DATA_W-1:0]           probe_wb,
   input  logic                        arm,
   input  logic                        abort,
   input  logic                        dump,
   input  logic [DATA_W-1:0]           trig_pc,
   input  logic [$clog2(DEPTH):0]      post_trig,
   output logic                        rd_valid,
   input  logic                        rd_ready,
   output logic [4*DATA_W-1:0]         rd_data,
   output logic                        rd_last,
   output logic [2:0]                  state,
   output logic                        triggered,
   output logic [$clog2(DEPTH):0]      fill_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] c_MAX_REM = CW'(DEPTH - 1);
   localparam logic [CW-1:0] c_FULL    = CW'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ARMED = 3'd1,
      S_POST  = 3'd2,
      S_DONE  = 3'd3,
      S_DUMP  = 3'd4
   } state_t;

   state_t            r_state;
   logic [AW-1:0]     r_wp;
   logic [AW-1:0]     r_rp;
   logic [CW-1:0]     r_fill;
   logic [CW-1:0]     r_rem;
   logic [CW-1:0]     r_cnt;
   logic              r_trig;
   logic [4*DATA_W-1:0] r_mem [DEPTH];

   logic              w_take;
   logic              w_hit;
   logic [CW-1:0]     w_rem_init;
   logic              w_xfer;

   assign w_take     = ((r_state == S_ARMED) || (r_state == S_POST)) &&
                       output_en && probe_valid && !abort;
   assign w_hit      = (r_state == S_ARMED) && (probe_pc == trig_pc);
   assign w_rem_init = (post_trig > c_MAX_REM) ? c_MAX_REM : post_trig;
   assign w_xfer     = (r_state == S_DUMP) && rd_ready;

   // Buffer contents need no reset; only entries inside the fill window are read.
   always_ff @(posedge clk) begin
      if (w_take) begin
         r_mem[r_wp] <= {probe_wb, probe_alu, probe_instr, probe_pc};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_wp    <= '0;
         r_rp    <= '0;
         r_fill  <= '0;
         r_rem   <= '0;
         r_cnt   <= '0;
         r_trig  <= 1'b0;
      end else if (abort) begin
         r_state <= S_IDLE;
         r_fill  <= '0;
         r_trig  <= 1'b0;
      end else begin
         if (w_take) begin
            r_wp <= r_wp + 1'b1;
            if (r_fill != c_FULL) begin
               r_fill <= r_fill + 1'b1;
            end
         end
         case (r_state)
            S_IDLE: begin
               if (arm) begin
                  r_wp    <= '0;
                  r_fill  <= '0;
                  r_trig  <= 1'b0;
                  r_state <= S_ARMED;
               end
            end
            S_ARMED: begin
               if (w_take && w_hit) begin
                  r_trig  <= 1'b1;
                  r_rem   <= w_rem_init;
                  r_state <= (w_rem_init == '0) ? S_DONE : S_POST;
               end
            end
            S_POST: begin
               if (w_take) begin
                  r_rem <= r_rem - 1'b1;
                  if (r_rem == CW'(1)) begin
                     r_state <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               if (dump) begin
                  // Full window (fill == DEPTH) wraps to rp == wp: oldest entry.
                  r_rp    <= r_wp - r_fill[AW-1:0];
                  r_cnt   <= r_fill;
                  r_state <= S_DUMP;
               end
            end
            S_DUMP: begin
               if (w_xfer) begin
                  r_rp  <= r_rp + 1'b1;
                  r_cnt <= r_cnt - 1'b1;
                  if (r_cnt == CW'(1)) begin
                     r_state <= S_IDLE;
                     r_fill  <= '0;
                     r_trig  <= 1'b0;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign rd_valid   = (r_state == S_DUMP);
   assign rd_data    = rd_valid ? r_mem[r_rp] : '0;
   assign rd_last    = rd_valid && (r_cnt == CW'(1));
   assign state      = r_state;
   assign triggered  = r_trig;
   assign fill_count = r_fill;

endmodule
`default_nettype wire
